// File: rtl/onn_pkg.sv
// ============================================================================
// onn_pkg : shared constants, FSM state codes and popcount for the ONN monitor
// rev 1.0
// ============================================================================
`default_nettype none

package onn_pkg;

  localparam int N_NEURON = 15;
  localparam int PHASE_W  = 4;
  localparam int PHI_W    = N_NEURON * PHASE_W;
  localparam int CNT_W    = $clog2(N_NEURON + 1);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DROP   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_SAMPLE = 3'd3;
  localparam state_t ST_EVAL   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  function automatic logic [CNT_W-1:0] popcount(input logic [0:N_NEURON-1] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onn_check_timer.sv
// ============================================================================
// onn_check_timer : loadable down-counter with terminal-count flag
// rev 1.0
// ============================================================================
`default_nettype none

module onn_check_timer #(
  parameter int W = 6
) (
  input  logic         sclk,
  input  logic         re,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge sclk) begin
    if (re) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/onn_convergence_monitor.sv
// ============================================================================
// onn_convergence_monitor : drop/check sequencing and convergence readout
// rev 1.0
// ============================================================================
`default_nettype none

module onn_convergence_monitor
  import onn_pkg::*;
#(
  parameter int DROP_CYCLES   = 32,
  parameter int CHECK_PERIOD  = 16,
  parameter int STABLE_CHECKS = 3,
  parameter int MAX_CHECKS    = 64
) (
  input  logic                               sclk,
  input  logic                               re,
  input  logic                               start,
  input  logic [0:N_NEURON-1]                state_changed,
  input  logic [0:PHI_W-1]                   phi_out,
  output logic                               drop,
  output logic                               state_cheak,
  output logic                               busy,
  output logic                               done,
  output logic                               converged,
  output logic [0:PHI_W-1]                   result_phase,
  output logic [CNT_W-1:0]                   changed_count,
  output logic [$clog2(MAX_CHECKS+1)-1:0]    checks_used
);

  localparam int CHK_W = $clog2(MAX_CHECKS + 1);
  localparam int STB_W = $clog2(STABLE_CHECKS + 1);
  localparam int TMR_W = $clog2(((DROP_CYCLES > CHECK_PERIOD) ? DROP_CYCLES : CHECK_PERIOD) + 1);

  localparam logic [TMR_W-1:0] DROP_LOAD   = TMR_W'(DROP_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(CHECK_PERIOD - 1);

  state_t             r_state;
  logic [STB_W-1:0]   r_stable;

  logic               w_accept;
  logic [CNT_W-1:0]   w_pop;
  logic [STB_W-1:0]   w_stable_next;
  logic [CHK_W-1:0]   w_checks_next;
  logic               w_conv_hit;
  logic               w_timeout_hit;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_load_val;
  logic               w_tmr_en;
  logic               w_tmr_tc;

  always_comb begin
    w_accept       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_pop          = popcount(state_changed);
    w_stable_next  = (w_pop == '0) ? (r_stable + 1'b1) : '0;
    w_checks_next  = checks_used + 1'b1;
    // Convergence takes priority over the check budget running out.
    w_conv_hit     = (r_state == ST_EVAL) && (w_stable_next == STB_W'(STABLE_CHECKS));
    w_timeout_hit  = (r_state == ST_EVAL) && !w_conv_hit && (w_checks_next == CHK_W'(MAX_CHECKS));
    w_tmr_load     = w_accept
                   || ((r_state == ST_DROP) && w_tmr_tc)
                   || ((r_state == ST_EVAL) && !w_conv_hit && !w_timeout_hit);
    w_tmr_load_val = w_accept ? DROP_LOAD : SETTLE_LOAD;
    w_tmr_en       = (r_state == ST_DROP) || (r_state == ST_SETTLE);
  end

  onn_check_timer #(
    .W (TMR_W)
  ) u_timer (
    .sclk     (sclk),
    .re       (re),
    .load     (w_tmr_load),
    .en       (w_tmr_en),
    .load_val (w_tmr_load_val),
    .tc       (w_tmr_tc)
  );

  always_ff @(posedge sclk) begin
    if (re) begin
      r_state       <= ST_IDLE;
      r_stable      <= '0;
      drop          <= 1'b0;
      state_cheak   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      result_phase  <= '0;
      changed_count <= '0;
      checks_used   <= '0;
    end else begin
      state_cheak <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_DROP;
            r_stable    <= '0;
            drop        <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            converged   <= 1'b0;
            checks_used <= '0;
          end
        end
        ST_DROP: begin
          if (w_tmr_tc) begin
            r_state <= ST_SETTLE;
            drop    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_tmr_tc) begin
            r_state     <= ST_SAMPLE;
            state_cheak <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          changed_count <= w_pop;
          checks_used   <= w_checks_next;
          r_stable      <= w_stable_next;
          if (w_conv_hit || w_timeout_hit) begin
            r_state      <= ST_DONE;
            converged    <= w_conv_hit;
            result_phase <= phi_out;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/onn_convergence_monitor.md
Name: onn_convergence_monitor

Overview:
- Controller and readout stage directly downstream of the 3x5 oscillatory neuron bank.
- Generates the `drop` (noise-injection window) and `state_cheak` (phase-check strobe) controls the bank consumes.
- Samples the bank's per-neuron `state_changed` flags after each strobe, counts consecutive quiet checks, and declares convergence or timeout.
- On completion, freezes the bank's 60-bit phase vector as the recalled pattern for the host/readout logic.

Parameters:
- N_NEURON, 15, number of neurons in the bank.
- PHASE_W, 4, phase width per neuron.
- DROP_CYCLES, 32, sclk cycles `drop` is held high at the start of a run.
- CHECK_PERIOD, 16, sclk cycles between consecutive `state_cheak` strobes (>=4).
- STABLE_CHECKS, 3, consecutive checks with zero changed neurons needed for convergence.
- MAX_CHECKS, 64, check budget before timeout.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- re  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a recall run; ignored unless in IDLE or DONE.
- state_changed  in  [0:N_NEURON-1]  per-neuron change flags from the bank.
- phi_out  in  [0:N_NEURON*PHASE_W-1]  bank phase vector, neuron i at bits [PHASE_W*i +: PHASE_W].
- drop  out  1  noise/drop window to the bank.
- state_cheak  out  1  one-cycle check strobe to the bank.
- busy  out  1  high from accepted start until done.
- done  out  1  high in DONE; held until next accepted start or reset.
- converged  out  1  valid when done; 1 = stable, 0 = timeout.
- result_phase  out  [0:N_NEURON*PHASE_W-1]  phase vector latched at completion.
- changed_count  out  $clog2(N_NEURON+1)  popcount of `state_changed` at the last evaluated check.
- checks_used  out  $clog2(MAX_CHECKS+1)  number of checks evaluated in the run.

Behaviour:
- Reset (re=1 at edge), all outputs 0:
  - drop, state_cheak, busy, done, converged, result_phase, changed_count, checks_used = 0.
  - FSM = IDLE; internal counters = 0.
  - Reset mid-run aborts immediately, with no latch of result_phase.
- FSM states: IDLE, DROP, SETTLE, SAMPLE, EVAL, DONE.
- IDLE/DONE + start=1:
  - Next cycle: DROP, busy=1, done=0, converged=0, checks_used=0, stable count=0, timer=0.
  - result_phase keeps its previous value until the new completion.
- DROP:
  - drop=1 for exactly DROP_CYCLES cycles.
  - Then enter SETTLE with drop=0 and the timer cleared.
- SETTLE:
  - Timer counts to CHECK_PERIOD-1.
  - On the terminal count, drive state_cheak=1 for one cycle and go to SAMPLE.
- SAMPLE:
  - One cycle wait; the bank's flags are valid one cycle after the strobe.
  - Go to EVAL.
- EVAL (one cycle): capture changed_count = popcount(state_changed); checks_used += 1.
  - If changed_count==0, stable += 1; else stable = 0.
  - If the updated stable == STABLE_CHECKS, then converged=1, latch result_phase=phi_out, go to DONE.
  - Else if the updated checks_used == MAX_CHECKS, then converged=0, latch result_phase=phi_out, go to DONE (timeout).
  - Else return to SETTLE with the timer cleared.
  - Convergence wins when both conditions hit in the same EVAL.
- Strobe spacing: strobe-to-strobe spacing in steady state is exactly CHECK_PERIOD+2 cycles (SETTLE count + SAMPLE + EVAL).
- DONE: busy=0, done=1; outputs stable. A start in DONE restarts exactly as from IDLE.
- start while busy: ignored, with no effect on counters.
- Latency, start to earliest done: 1 + DROP_CYCLES + STABLE_CHECKS*(CHECK_PERIOD+2) cycles.
- Arithmetic:
  - Counters are unsigned and saturate-free; widths are sized by `$clog2` so wrap cannot occur within the legal parameter range.
  - popcount is combinational over N_NEURON bits and registered in EVAL.

Decomposition:
- Shared package `onn_pkg`:
  - FSM state enum (IDLE, DROP, SETTLE, SAMPLE, EVAL, DONE).
  - N_NEURON=15, PHASE_W=4, and the derived PHI_W=60.
  - A popcount function.
- One natural sub-module, `onn_check_timer`: a programmable down-counter with load/enable/terminal-count, instantiated once and reused for the DROP and SETTLE intervals.

Test Plan:
- Reset then idle: hold re=1 for 2 cycles, then release with start=0 for 100 cycles -> all outputs stay 0; no drop or strobe pulses.
- Immediate convergence: start pulse; state_changed=0 throughout -> drop high for exactly 32 cycles; strobes 18 cycles apart; done at cycle 1+32+3*18=87 after start; converged=1; checks_used=3; result_phase = phi_out (drive 60'h123456789ABCDEF) at the third EVAL.
- Stability reset: state_changed=15'h0004 at check 2, then 0 -> stable counter restarts; done after check 5; changed_count=0; checks_used=5.
- Timeout: state_changed=15'h7FFF at every check -> done after 64 checks; converged=0; checks_used=64; changed_count=15; result_phase latched at the 64th EVAL.
- Start ignored and restart: a start pulse during SETTLE has no effect on the strobe count; after done, a new start clears done/converged next cycle while result_phase is retained until the new completion.
- Reset mid-run: assert re during SETTLE of check 2 -> next cycle all outputs 0 and FSM IDLE; a following start runs a full, correct sequence.
